// File: rtl/trng_conditioner.sv
// Raw TRNG post-processor: repetition-count health test, optional von Neumann
// de-biasing, and MSB-first packing into words on a valid/ready output.
module trng_conditioner #(
    parameter int WORD_W    = 8,
    parameter int REP_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              raw_bit,
    input  logic              raw_valid,
    input  logic              vn_mode,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              health_fail,
    output logic              overrun,
    input  logic              clr_fail
);

    localparam int              CW       = $clog2(WORD_W + 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(WORD_W);
    localparam logic [7:0]      REP_MAX  = 8'(REP_LIMIT);

    logic [WORD_W-1:0] sr_q, sr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              health_fail_q, health_fail_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        rep_cnt_q, rep_cnt_d;
    logic              last_bit_q, last_bit_d;
    logic              phase_q, phase_d;
    logic              first_q, first_d;
    logic              vn_prev_q, vn_prev_d;
    logic              cbit_q, cbit_d;
    logic              cbit_vld_q, cbit_vld_d;

    logic              accept;
    logic              phase_eff;
    logic              trip;
    logic              full;

    always_comb begin
        sr_d          = sr_q;
        cnt_d         = cnt_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        health_fail_d = health_fail_q;
        overrun_d     = overrun_q;
        rep_cnt_d     = rep_cnt_q;
        last_bit_d    = last_bit_q;
        first_d       = first_q;
        vn_prev_d     = vn_mode;
        cbit_d        = cbit_q;
        cbit_vld_d    = 1'b0;
        trip          = 1'b0;

        accept    = raw_valid && !health_fail_q;
        phase_eff = (vn_mode != vn_prev_q) ? 1'b0 : phase_q;
        phase_d   = phase_eff;
        full      = (cnt_q == CNT_FULL);

        // Stage 1: health test and conditioning on the raw bit
        if (accept) begin
            last_bit_d = raw_bit;
            if (rep_cnt_q != 8'd0 && raw_bit == last_bit_q) begin
                rep_cnt_d = (rep_cnt_q == REP_MAX) ? REP_MAX : rep_cnt_q + 8'd1;
            end else begin
                rep_cnt_d = 8'd1;
            end
            trip = (rep_cnt_d == REP_MAX);

            if (!vn_mode) begin
                cbit_vld_d = 1'b1;
                cbit_d     = raw_bit;
                phase_d    = 1'b0;
            end else if (!phase_eff) begin
                first_d = raw_bit;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (first_q != raw_bit) begin
                    cbit_vld_d = 1'b1;
                    cbit_d     = first_q;
                end
            end
        end

        // Stage 2: packing and word hand-off
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (full && (!out_valid_q || out_ready)) begin
            out_data_d  = sr_q;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            if (cbit_vld_q) begin
                sr_d  = {sr_q[WORD_W-2:0], cbit_q};
                cnt_d = CW'(1);
            end
        end else if (cbit_vld_q) begin
            if (full) begin
                overrun_d = 1'b1;
            end else begin
                sr_d  = {sr_q[WORD_W-2:0], cbit_q};
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (trip) begin
            health_fail_d = 1'b1;
            out_valid_d   = 1'b0;
            sr_d          = '0;
            cnt_d         = '0;
            phase_d       = 1'b0;
            cbit_vld_d    = 1'b0;
        end

        // Recovery discards everything in flight, including this cycle's raw bit
        if (clr_fail) begin
            health_fail_d = 1'b0;
            overrun_d     = 1'b0;
            rep_cnt_d     = 8'd0;
            last_bit_d    = 1'b0;
            sr_d          = '0;
            cnt_d         = '0;
            phase_d       = 1'b0;
            out_valid_d   = 1'b0;
            cbit_vld_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q          <= '0;
            cnt_q         <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            health_fail_q <= 1'b0;
            overrun_q     <= 1'b0;
            rep_cnt_q     <= 8'd0;
            last_bit_q    <= 1'b0;
            phase_q       <= 1'b0;
            first_q       <= 1'b0;
            vn_prev_q     <= 1'b0;
            cbit_q        <= 1'b0;
            cbit_vld_q    <= 1'b0;
        end else if (ena) begin
            sr_q          <= sr_d;
            cnt_q         <= cnt_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            health_fail_q <= health_fail_d;
            overrun_q     <= overrun_d;
            rep_cnt_q     <= rep_cnt_d;
            last_bit_q    <= last_bit_d;
            phase_q       <= phase_d;
            first_q       <= first_d;
            vn_prev_q     <= vn_prev_d;
            cbit_q        <= cbit_d;
            cbit_vld_q    <= cbit_vld_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign health_fail = health_fail_q;
    assign overrun     = overrun_q;

endmodule
